// File: rtl/ahb_sub_pkg.sv
// Shared AHB-Lite codes, FSM state encoding and register offsets for the
// ahb_sub_mc register/push slave.
package ahb_sub_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [1:0] HSIZE_DWORD = 2'b11;

  localparam int unsigned ADDR_WEIGHT = 'h000;
  localparam int unsigned ADDR_INPUT  = 'h008;
  localparam int unsigned ADDR_BIAS   = 'h010;
  localparam int unsigned ADDR_CTRL   = 'h018;
  localparam int unsigned ADDR_OUT0   = 'h020;

  // Read-only bytes of the control word: status (byte 2) and err (bytes 4-5).
  localparam logic [7:0] CTRL_RO_MASK = 8'b0011_0100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PUSH_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // All burst codes are legal; every beat is decoded on its own.
  function automatic logic burst_known(input logic [2:0] hburst);
    case (hburst)
      HBURST_SINGLE, HBURST_INCR, HBURST_WRAP4, HBURST_INCR4,
      HBURST_WRAP8, HBURST_INCR8, HBURST_WRAP16, HBURST_INCR16: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_byte_strobe.sv
// Byte-lane strobe and natural-alignment check for a 64-bit AHB data bus.
module ahb_byte_strobe
  import ahb_sub_pkg::*;
(
  input  logic [1:0] hsize,
  input  logic [2:0] addr_lo,
  output logic [7:0] strobe,
  output logic       misaligned
);

  logic [7:0] base;
  logic [2:0] low_mask;

  always_comb begin
    base     = 8'h01;
    low_mask = 3'b000;
    case (hsize)
      2'b00: begin base = 8'h01; low_mask = 3'b000; end
      2'b01: begin base = 8'h03; low_mask = 3'b001; end
      2'b10: begin base = 8'h0F; low_mask = 3'b011; end
      2'b11: begin base = 8'hFF; low_mask = 3'b111; end
      default: ;
    endcase
    strobe     = base << addr_lo;
    misaligned = |(addr_lo & low_mask);
  end

endmodule

// File: rtl/ahb_sub_mc.sv
// AHB-Lite slave: bias/ctrl register file, read-only output channels and a
// weight/input push port with bounded wait states and a two-cycle ERROR.
module ahb_sub_mc
  import ahb_sub_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int ADDR_W        = 10,
  parameter int PUSH_WAIT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 hsel,
  input  logic [ADDR_W-1:0]    haddr,
  input  logic [1:0]           htrans,
  input  logic [1:0]           hsize,
  input  logic                 hwrite,
  input  logic [2:0]           hburst,
  input  logic [63:0]          hwdata,
  output logic [63:0]          hrdata,
  output logic                 hready,
  output logic                 hresp,
  input  logic [7:0]           status_reg,
  input  logic [15:0]          err_reg,
  input  logic [NUM_CH*64-1:0] output_data,
  input  logic                 push_ready,
  output logic [63:0]          bias_reg,
  output logic [7:0]           ctrl_reg,
  output logic [2:0]           act_mode,
  output logic                 handshake,
  output logic                 wr_en_push,
  output logic [63:0]          push_data,
  output logic                 is_weight
);

  localparam int WORD_W = ADDR_W - 3;
  localparam int WAIT_W = $clog2(PUSH_WAIT_MAX + 1);
  localparam logic [WORD_W-1:0] W_WEIGHT = WORD_W'(ADDR_WEIGHT >> 3);
  localparam logic [WORD_W-1:0] W_INPUT  = WORD_W'(ADDR_INPUT >> 3);
  localparam logic [WORD_W-1:0] W_BIAS   = WORD_W'(ADDR_BIAS >> 3);
  localparam logic [WORD_W-1:0] W_CTRL   = WORD_W'(ADDR_CTRL >> 3);
  localparam logic [WORD_W-1:0] W_OUT0   = WORD_W'(ADDR_OUT0 >> 3);
  localparam logic [WORD_W-1:0] W_END    = WORD_W'((ADDR_OUT0 >> 3) + NUM_CH);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                write_q, write_d;
  logic [7:0]          strobe_q, strobe_d;
  logic                is_weight_q, is_weight_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [63:0]         bias_q, bias_d;
  logic [7:0]          ctrl_q, ctrl_d;
  logic [2:0]          act_q, act_d;
  logic                handshake_q, handshake_d;

  logic [WORD_W-1:0]   a_word;
  logic [7:0]          a_strobe;
  logic                a_misaligned, a_push, a_err, accept;
  logic [63:0]         rd_word, rd_mask;

  assign a_word = haddr[ADDR_W-1:3];

  ahb_byte_strobe u_strobe (
    .hsize      (hsize),
    .addr_lo    (haddr[2:0]),
    .strobe     (a_strobe),
    .misaligned (a_misaligned)
  );

  always_comb begin
    a_push = (a_word == W_WEIGHT) || (a_word == W_INPUT);
    a_err  = a_misaligned
          || (a_word >= W_END)
          || (hwrite && a_word >= W_OUT0)
          || (hwrite && a_word == W_CTRL && |(a_strobe & CTRL_RO_MASK))
          || (!hwrite && a_push)
          || (hwrite && a_push && hsize != HSIZE_DWORD);
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    word_d      = word_q;
    write_d     = write_q;
    strobe_d    = strobe_q;
    is_weight_d = is_weight_q;
    hready      = 1'b1;
    hresp       = 1'b0;
    wr_en_push  = 1'b0;
    accept      = 1'b0;
    case (state_q)
      ST_PUSH_WAIT: begin
        hready     = push_ready;
        wr_en_push = push_ready;
        if (!push_ready) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q == WAIT_W'(PUSH_WAIT_MAX - 1)) state_d = ST_ERR1;
        end
      end
      ST_ERR1: begin
        hready  = 1'b0;
        hresp   = 1'b1;
        state_d = ST_ERR2;
      end
      ST_ERR2: hresp = 1'b1;
      default: ;
    endcase
    // Any cycle that completes a data phase also samples the next address phase.
    if (hready) begin
      accept  = hsel && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) && burst_known(hburst);
      state_d = ST_IDLE;
      if (accept) begin
        word_d      = a_word;
        write_d     = hwrite;
        strobe_d    = a_strobe;
        is_weight_d = (a_word == W_WEIGHT);
        wait_cnt_d  = '0;
        if (a_err)                 state_d = ST_ERR1;
        else if (hwrite && a_push) state_d = ST_PUSH_WAIT;
        else                       state_d = ST_DATA;
      end
    end
  end

  always_comb begin
    bias_d      = bias_q;
    ctrl_d      = {ctrl_q[7:1], 1'b0};
    act_d       = act_q;
    handshake_d = 1'b0;
    if (state_q == ST_DATA && write_q) begin
      if (word_q == W_BIAS) begin
        for (int b = 0; b < 8; b++) begin
          if (strobe_q[b]) bias_d[8*b +: 8] = hwdata[8*b +: 8];
        end
      end
      if (word_q == W_CTRL) begin
        if (strobe_q[0]) begin
          ctrl_d      = hwdata[7:0];
          handshake_d = hwdata[0];
        end
        if (strobe_q[1]) act_d = hwdata[10:8];
      end
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_rd_mask
    assign rd_mask[8*gi +: 8] = {8{strobe_q[gi]}};
  end

  // Reads are combinational from the registers, so a write in the preceding
  // data phase is already visible here.
  always_comb begin
    rd_word = '0;
    if (word_q == W_BIAS) rd_word = bias_q;
    if (word_q == W_CTRL) rd_word = {16'h0, err_reg, 8'h0, status_reg, 5'h0, act_q, ctrl_q};
    for (int k = 0; k < NUM_CH; k++) begin
      if (word_q == W_OUT0 + WORD_W'(k)) rd_word = output_data[64*k +: 64];
    end
    hrdata = (state_q == ST_DATA && !write_q) ? (rd_word & rd_mask) : '0;
  end

  assign push_data = (state_q == ST_PUSH_WAIT) ? hwdata : '0;
  assign is_weight = (state_q == ST_PUSH_WAIT) && is_weight_q;
  assign bias_reg  = bias_q;
  assign ctrl_reg  = ctrl_q;
  assign act_mode  = act_q;
  assign handshake = handshake_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      write_q     <= 1'b0;
      strobe_q    <= '0;
      is_weight_q <= 1'b0;
      wait_cnt_q  <= '0;
      bias_q      <= '0;
      ctrl_q      <= '0;
      act_q       <= '0;
      handshake_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      write_q     <= write_d;
      strobe_q    <= strobe_d;
      is_weight_q <= is_weight_d;
      wait_cnt_q  <= wait_cnt_d;
      bias_q      <= bias_d;
      ctrl_q      <= ctrl_d;
      act_q       <= act_d;
      handshake_q <= handshake_d;
    end
  end

endmodule

// File: tb/tb_ahb_sub_mc.sv
// Pipelined AHB-Lite master with a response scoreboard for ahb_sub_mc.
module tb_ahb_sub_mc;
  import ahb_sub_pkg::*;

  typedef struct {
    string       tag;
    logic [1:0]  trans;
    logic        wr;
    logic [9:0]  addr;
    logic [1:0]  size;
    logic [63:0] wdata;
    int          pr_delay;
    logic        exp_err;
    int          exp_waits;
    logic        chk_rd;
    logic [63:0] exp_rd;
  } beat_t;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         hsel = 1'b0;
  logic [9:0]   haddr = '0;
  logic [1:0]   htrans = HTRANS_IDLE;
  logic [1:0]   hsize = '0;
  logic         hwrite = 1'b0;
  logic [2:0]   hburst = HBURST_SINGLE;
  logic [63:0]  hwdata = '0;
  logic [63:0]  hrdata;
  logic         hready, hresp;
  logic [7:0]   status_reg = 8'h5A;
  logic [15:0]  err_reg = 16'hBEEF;
  logic [127:0] output_data = {64'hCAFE_F00D_1234_5678, 64'h1111_2222_3333_4444};
  logic         push_ready = 1'b0;
  logic [63:0]  bias_reg, push_data;
  logic [7:0]   ctrl_reg;
  logic [2:0]   act_mode;
  logic         handshake, wr_en_push, is_weight;

  int n_tests = 0;
  int n_fail = 0;
  int push_cnt = 0;
  int hs_cnt = 0;
  logic [63:0] last_push_data = '0;
  logic        last_is_weight = 1'b0;
  beat_t beats[$];
  beat_t sb[$];

  ahb_sub_mc dut (
    .clk(clk), .n_rst(n_rst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hwrite(hwrite), .hburst(hburst), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp), .status_reg(status_reg),
    .err_reg(err_reg), .output_data(output_data), .push_ready(push_ready),
    .bias_reg(bias_reg), .ctrl_reg(ctrl_reg), .act_mode(act_mode),
    .handshake(handshake), .wr_en_push(wr_en_push), .push_data(push_data),
    .is_weight(is_weight)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en_push) begin
      push_cnt       <= push_cnt + 1;
      last_push_data <= push_data;
      last_is_weight <= is_weight;
    end
    if (handshake) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic add(input string tag, input logic [1:0] tr, input logic wr,
                     input logic [9:0] a, input logic [1:0] sz, input logic [63:0] wd,
                     input int prd, input logic eerr, input int ew,
                     input logic crd, input logic [63:0] erd);
    beat_t b;
    b.tag = tag; b.trans = tr; b.wr = wr; b.addr = a; b.size = sz; b.wdata = wd;
    b.pr_delay = prd; b.exp_err = eerr; b.exp_waits = ew; b.chk_rd = crd; b.exp_rd = erd;
    beats.push_back(b);
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_beats();
    beat_t b;
    int i = 0;
    int dp_cyc = 0;
    int guard = 0;
    while ((i < beats.size() || sb.size() > 0) && guard < 400) begin
      if (i < beats.size()) begin
        hsel = 1'b1; htrans = beats[i].trans; hwrite = beats[i].wr;
        haddr = beats[i].addr; hsize = beats[i].size;
      end else begin
        hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
      end
      if (sb.size() > 0) begin
        hwdata     = sb[0].wdata;
        push_ready = (dp_cyc >= sb[0].pr_delay);
      end else begin
        push_ready = 1'b0;
      end
      @(negedge clk);
      if (sb.size() > 0) begin
        if (hready) begin
          b = sb.pop_front();
          $display("[TB] %-14s resp=%0d waits=%0d hrdata=%h", b.tag, hresp, dp_cyc, hrdata);
          chk_eq({b.tag, "_resp"}, 64'(hresp), 64'(b.exp_err));
          chk_eq({b.tag, "_waits"}, 64'(dp_cyc), 64'(b.exp_waits));
          if (b.chk_rd) chk_eq({b.tag, "_rdata"}, hrdata, b.exp_rd);
          dp_cyc = 0;
        end else begin
          dp_cyc++;
        end
      end
      if (hready && i < beats.size()) begin
        sb.push_back(beats[i]);
        i++;
      end
      @(posedge clk); #1;
      guard++;
    end
    chk_eq("beats_completed", 64'(i == beats.size() && sb.size() == 0), 64'd1);
    beats.delete();
    sb.delete();
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; push_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int hs_base;

    repeat (2) @(negedge clk);
    chk_eq("reset_flags", 64'({hready, hresp, wr_en_push, is_weight, handshake}), 64'b10000);
    chk_eq("reset_hrdata", hrdata, 64'h0);
    chk_eq("reset_bias", bias_reg, 64'h0);
    chk_eq("reset_ctrl_act", 64'({ctrl_reg, act_mode}), 64'h0);
    chk_eq("reset_push_data", push_data, 64'h0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Full-width write then back-to-back read of bias.
    add("wr_bias", HTRANS_NONSEQ, 1, 10'h010, 2'd3, 64'h0003_0003_0003_0003, 0, 0, 0, 0, 0);
    add("rd_bias", HTRANS_NONSEQ, 0, 10'h010, 2'd3, 64'h0, 0, 0, 0, 1, 64'h0003_0003_0003_0003);
    add("wr_bias_b2", HTRANS_NONSEQ, 1, 10'h012, 2'd0, 64'h0000_0000_00AA_0000, 0, 0, 0, 0, 0);
    add("rd_bias_h4", HTRANS_NONSEQ, 0, 10'h014, 2'd1, 64'h0, 0, 0, 0, 1, 64'h0000_0003_0000_0000);
    add("rd_bias_full", HTRANS_NONSEQ, 0, 10'h010, 2'd3, 64'h0, 0, 0, 0, 1, 64'h0003_0003_00AA_0003);
    run_beats();
    chk_eq("bias_after_narrow", bias_reg, 64'h0003_0003_00AA_0003);

    // Control word: act_mode byte write, RO byte write, status/err reads.
    add("wr_act", HTRANS_NONSEQ, 1, 10'h019, 2'd0, 64'h0000_0000_0000_0500, 0, 0, 0, 0, 0);
    add("wr_status_err", HTRANS_NONSEQ, 1, 10'h01A, 2'd0, 64'h0000_0000_00FF_0000, 0, 1, 1, 0, 0);
    add("rd_ctrl_lo", HTRANS_NONSEQ, 0, 10'h018, 2'd2, 64'h0, 0, 0, 0, 1, 64'h0000_0000_005A_0500);
    add("rd_err_reg", HTRANS_NONSEQ, 0, 10'h01C, 2'd1, 64'h0, 0, 0, 0, 1, 64'h0000_BEEF_0000_0000);
    run_beats();
    chk_eq("act_mode", 64'(act_mode), 64'd5);

    // Output channels.
    add("rd_ch1", HTRANS_NONSEQ, 0, 10'h028, 2'd3, 64'h0, 0, 0, 0, 1, 64'hCAFE_F00D_1234_5678);
    add("rd_ch0", HTRANS_NONSEQ, 0, 10'h020, 2'd3, 64'h0, 0, 0, 0, 1, 64'h1111_2222_3333_4444);
    add("rd_unmapped", HTRANS_NONSEQ, 0, 10'h030, 2'd3, 64'h0, 0, 1, 1, 0, 0);
    run_beats();

    // Push with three wait states, then a push that times out.
    base = push_cnt;
    add("push_weight", HTRANS_NONSEQ, 1, 10'h000, 2'd3, 64'hDEAD_BEEF_0123_4567, 3, 0, 3, 0, 0);
    run_beats();
    chk_eq("push_weight_cnt", 64'(push_cnt - base), 64'd1);
    chk_eq("push_weight_data", last_push_data, 64'hDEAD_BEEF_0123_4567);
    chk_eq("push_weight_isw", 64'(last_is_weight), 64'd1);
    base = push_cnt;
    add("push_timeout", HTRANS_NONSEQ, 1, 10'h008, 2'd3, 64'h7777_0000_7777_0000, 1000, 1, 16, 0, 0);
    run_beats();
    chk_eq("push_timeout_cnt", 64'(push_cnt - base), 64'd0);

    // Other error classes: no side effects.
    base = push_cnt;
    add("rd_push_err", HTRANS_NONSEQ, 0, 10'h000, 2'd3, 64'h0, 0, 1, 1, 0, 0);
    add("misalign_err", HTRANS_NONSEQ, 1, 10'h011, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 1, 0, 0);
    add("push_size_err", HTRANS_NONSEQ, 1, 10'h008, 2'd2, 64'h1234_1234_1234_1234, 0, 1, 1, 0, 0);
    add("wr_chan_err", HTRANS_NONSEQ, 1, 10'h020, 2'd3, 64'h1, 0, 1, 1, 0, 0);
    run_beats();
    chk_eq("err_no_push", 64'(push_cnt - base), 64'd0);
    chk_eq("err_bias_kept", bias_reg, 64'h0003_0003_00AA_0003);

    // INCR4 with a BUSY beat: two pushes and a bias update.
    base = push_cnt;
    hburst = HBURST_INCR4;
    add("b_push_w", HTRANS_NONSEQ, 1, 10'h000, 2'd3, 64'hAAAA_0000_AAAA_0001, 0, 0, 0, 0, 0);
    add("b_busy", HTRANS_BUSY, 1, 10'h008, 2'd3, 64'h0, 0, 0, 0, 0, 0);
    add("b_push_i", HTRANS_SEQ, 1, 10'h008, 2'd3, 64'hBBBB_0000_BBBB_0002, 2, 0, 2, 0, 0);
    add("b_bias", HTRANS_SEQ, 1, 10'h010, 2'd3, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 0);
    run_beats();
    hburst = HBURST_SINGLE;
    chk_eq("burst_push_cnt", 64'(push_cnt - base), 64'd2);
    chk_eq("burst_last_data", last_push_data, 64'hBBBB_0000_BBBB_0002);
    chk_eq("burst_last_isw", 64'(last_is_weight), 64'd0);
    chk_eq("burst_bias", bias_reg, 64'h0123_4567_89AB_CDEF);

    // Handshake pulse from ctrl bit0.
    hs_base = hs_cnt;
    add("wr_ctrl_go", HTRANS_NONSEQ, 1, 10'h018, 2'd0, 64'h0000_0000_0000_0001, 0, 0, 0, 0, 0);
    run_beats();
    repeat (3) @(posedge clk);
    #1;
    chk_eq("handshake_pulses", 64'(hs_cnt - hs_base), 64'd1);
    chk_eq("ctrl_selfclear", 64'(ctrl_reg), 64'h0);
    chk_eq("act_kept", 64'(act_mode), 64'd5);

    // Reset asserted in the middle of a push wait.
    base = push_cnt;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 10'h000; hsize = 2'd3;
    push_ready = 1'b0;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hwdata = 64'h5555_AAAA_5555_AAAA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("pw_hready_low", 64'(hready), 64'd0);
    chk_eq("pw_push_data", push_data, 64'h5555_AAAA_5555_AAAA);
    #1;
    n_rst = 1'b0;
    #1;
    chk_eq("rst_async_flags", 64'({hready, hresp, wr_en_push, is_weight, handshake}), 64'b10000);
    chk_eq("rst_async_push_data", push_data, 64'h0);
    chk_eq("rst_async_bias", bias_reg, 64'h0);
    chk_eq("rst_async_ctrl_act", 64'({ctrl_reg, act_mode}), 64'h0);
    chk_eq("rst_async_hrdata", hrdata, 64'h0);
    push_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_eq("rst_no_push_after", 64'(push_cnt - base), 64'd0);
    chk_eq("rst_hready_idle", 64'(hready), 64'd1);
    push_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
